// File: rtl/seg_scan_ctrl_if.sv
// ============================================================================
// Module   : seg_scan_ctrl_if
// Brief    : Pattern-load and display bus of the multiplexed 7-segment scanner
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg_scan_ctrl_if;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic [6:0] seg3;
  logic [6:0] seg4;
  logic [6:0] seg5;
  logic [6:0] seg6;
  logic [5:0] en_mask;
  logic       load;
  logic [6:0] seg_out;
  logic [5:0] dig_en;
  logic       pending;
  logic       frame_done;

  modport master (
    output seg1, seg2, seg3, seg4, seg5, seg6, en_mask, load,
    input  seg_out, dig_en, pending, frame_done
  );

  modport slave (
    input  seg1, seg2, seg3, seg4, seg5, seg6, en_mask, load,
    output seg_out, dig_en, pending, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Six-digit 7-segment scanner with blanking guard and
//            frame-synchronous double-buffered pattern update
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
  parameter int unsigned DWELL   = 4,
  parameter int unsigned BLANK   = 1,
  parameter logic [6:0]  SEG_OFF = 7'b1111111
) (
  input wire logic       clk,
  input wire logic       reset,
  seg_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  localparam logic [15:0] c_dwell_last = 16'(DWELL - 1);
  localparam logic [15:0] c_blank_last = 16'(BLANK - 1);
  localparam bit          c_has_blank  = (BLANK != 0);
  localparam state_t      c_slot_first = c_has_blank ? S_BLANK : S_SHOW;

  state_t          r_state;
  logic [2:0]      r_idx;
  logic [15:0]     r_cnt;
  logic [5:0][6:0] r_act;
  logic [5:0]      r_act_mask;
  logic [5:0][6:0] r_sh;
  logic [5:0]      r_sh_mask;
  logic            r_pending;
  logic [6:0]      r_seg_out;
  logic [5:0]      r_dig_en;
  logic            r_frame_done;

  state_t          w_state_nxt;
  logic [2:0]      w_idx_nxt;
  logic [15:0]     w_cnt_nxt;
  logic            w_swap;
  logic [5:0][6:0] w_act_nxt;
  logic [5:0]      w_mask_nxt;
  logic            w_lit;
  logic [6:0]      w_seg_nxt;
  logic [5:0]      w_dig_nxt;
  logic            w_fd_nxt;
  logic [5:0][6:0] w_seg_in;

  assign w_seg_in = {bus.seg6, bus.seg5, bus.seg4, bus.seg3, bus.seg2, bus.seg1};

  // Frame boundaries (IDLE exit and the d5->d0 wrap) are the only swap points.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + 16'd1;
    w_swap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = c_slot_first;
        w_idx_nxt   = 3'd0;
        w_cnt_nxt   = 16'd0;
        w_swap      = 1'b1;
      end
      S_BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_state_nxt = S_SHOW;
          w_cnt_nxt   = 16'd0;
        end
      end
      S_SHOW: begin
        if (r_cnt == c_dwell_last) begin
          w_state_nxt = c_slot_first;
          w_cnt_nxt   = 16'd0;
          if (r_idx == 3'd5) begin
            w_idx_nxt = 3'd0;
            w_swap    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 3'd0;
        w_cnt_nxt   = 16'd0;
      end
    endcase

    w_act_nxt  = (w_swap && r_pending) ? r_sh      : r_act;
    w_mask_nxt = (w_swap && r_pending) ? r_sh_mask : r_act_mask;
    w_lit      = (w_state_nxt == S_SHOW) && w_mask_nxt[w_idx_nxt];
    w_seg_nxt  = w_lit ? w_act_nxt[w_idx_nxt] : SEG_OFF;
    w_dig_nxt  = w_lit ? (6'b000001 << w_idx_nxt) : 6'b000000;
    w_fd_nxt   = (w_state_nxt == S_SHOW) && (w_idx_nxt == 3'd5) &&
                 (w_cnt_nxt == c_dwell_last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      r_cnt        <= 16'd0;
      r_act        <= {6{SEG_OFF}};
      r_act_mask   <= 6'b111111;
      r_sh         <= {6{SEG_OFF}};
      r_sh_mask    <= 6'b111111;
      r_pending    <= 1'b0;
      r_seg_out    <= SEG_OFF;
      r_dig_en     <= 6'b000000;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_act        <= w_act_nxt;
      r_act_mask   <= w_mask_nxt;
      r_seg_out    <= w_seg_nxt;
      r_dig_en     <= w_dig_nxt;
      r_frame_done <= w_fd_nxt;
      if (w_swap && r_pending) begin
        r_pending <= 1'b0;
      end
      // A load on a swap edge lands after the transfer, so pending stays set.
      if (bus.load) begin
        r_sh      <= w_seg_in;
        r_sh_mask <= bus.en_mask;
        r_pending <= 1'b1;
      end
    end
  end

  assign bus.seg_out    = r_seg_out;
  assign bus.dig_en     = r_dig_en;
  assign bus.pending    = r_pending;
  assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Self-checking bench for seg_scan_ctrl (DWELL=4/BLANK=1 and
//            DWELL=1/BLANK=0 instances), frame-position reference model
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg_scan_ctrl_if bus ();
  seg_scan_ctrl_if bus2 ();

  seg_scan_ctrl #(.DWELL(4), .BLANK(1), .SEG_OFF(7'h7F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  seg_scan_ctrl #(.DWELL(1), .BLANK(0), .SEG_OFF(7'h7F)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  typedef struct {
    logic [6:0] seg;
    logic [5:0] dig;
    logic       pend;
    logic       fd;
  } exp_t;

  exp_t sbq[$];
  exp_t sbq2[$];

  int checks = 0;
  int errors = 0;

  logic [5:0][6:0] m_act, m_sh;
  logic [5:0]      m_mask, m_sh_mask;
  logic            m_pend;
  int              k;

  // Expected outputs from the position k within the frame (k=0 is the cycle after E0).
  function automatic exp_t predict(input int b, input int d, input int kk,
                                   input logic [5:0][6:0] act, input logic [5:0] mask,
                                   input logic pend);
    exp_t e;
    int f, p, slot, off;
    f      = 6 * (b + d);
    p      = kk % f;
    slot   = p / (b + d);
    off    = p % (b + d);
    e.seg  = 7'h7F;
    e.dig  = 6'b0;
    e.pend = pend;
    e.fd   = (p == f - 1);
    if (off >= b && mask[slot]) begin
      e.seg = act[slot];
      e.dig = 6'(1 << slot);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_act     = {6{7'h7F}};
    m_mask    = 6'h3F;
    m_sh      = {6{7'h7F}};
    m_sh_mask = 6'h3F;
    m_pend    = 1'b0;
    k         = -1;
  endtask

  task automatic cycle(input logic rst_v, input logic ld,
                       input logic [5:0][6:0] segs, input logic [5:0] mask);
    exp_t e, e2, idle;
    reset       = rst_v;
    bus.load    = ld;
    bus.seg1    = segs[0];
    bus.seg2    = segs[1];
    bus.seg3    = segs[2];
    bus.seg4    = segs[3];
    bus.seg5    = segs[4];
    bus.seg6    = segs[5];
    bus.en_mask = mask;
    @(posedge clk);
    idle.seg = 7'h7F; idle.dig = 6'b0; idle.pend = 1'b0; idle.fd = 1'b0;
    if (rst_v) begin
      model_reset();
      sbq.push_back(idle);
      sbq2.push_back(idle);
    end else begin
      k++;
      if ((k % 30) == 0 && m_pend) begin
        m_act  = m_sh;
        m_mask = m_sh_mask;
        m_pend = 1'b0;
      end
      if (ld) begin
        m_sh      = segs;
        m_sh_mask = mask;
        m_pend    = 1'b1;
      end
      sbq.push_back(predict(1, 4, k, m_act, m_mask, m_pend));
      sbq2.push_back(predict(0, 1, k, {6{7'h7F}}, 6'h3F, 1'b0));
    end
    #1;
    if (sbq.size() == 0 || sbq2.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty k=%0d observed=0 expected=1", k);
    end else begin
      e  = sbq.pop_front();
      e2 = sbq2.pop_front();
      chk("seg_out",     bus.seg_out,               e.seg);
      chk("dig_en",      {1'b0, bus.dig_en},        {1'b0, e.dig});
      chk("pending",     {6'b0, bus.pending},       {6'b0, e.pend});
      chk("frame_done",  {6'b0, bus.frame_done},    {6'b0, e.fd});
      chk("b0_seg_out",  bus2.seg_out,              e2.seg);
      chk("b0_dig_en",   {1'b0, bus2.dig_en},       {1'b0, e2.dig});
      chk("b0_frame_done", {6'b0, bus2.frame_done}, {6'b0, e2.fd});
    end
  endtask

  initial begin
    logic [5:0][6:0] segs;
    logic [5:0]      mask;
    logic            ld;

    bus2.seg1 = 7'h00; bus2.seg2 = 7'h00; bus2.seg3 = 7'h00;
    bus2.seg4 = 7'h00; bus2.seg5 = 7'h00; bus2.seg6 = 7'h00;
    bus2.en_mask = 6'h00; bus2.load = 1'b0;
    model_reset();

    segs = {6{7'h7F}};
    cycle(1'b1, 1'b0, segs, 6'h3F);
    segs[0] = 7'h01;
    cycle(1'b1, 1'b1, segs, 6'h01);   // load under reset must be dropped
    cycle(1'b1, 1'b0, {6{7'h7F}}, 6'h3F);

    // Phase A: deferred swap, last-load-wins, masked digit, then mid-frame reset.
    for (int i = 0; i < 107; i++) begin
      ld   = 1'b0;
      segs = {6{7'h7F}};
      mask = 6'h3F;
      case (i)
        3:  begin ld = 1'b1; segs[0] = 7'h40; segs[1] = 7'h79; end
        33: begin ld = 1'b1; segs[0] = 7'h40; segs[1] = 7'h79; end
        40: begin ld = 1'b1; segs[0] = 7'h24; segs[1] = 7'h79; end
        65: begin ld = 1'b1; segs[0] = 7'h12; segs[2] = 7'h30; mask = 6'h3E; end
        92: begin ld = 1'b1; segs[0] = 7'h00; end
        default: ;
      endcase
      cycle(1'b0, ld, segs, mask);
      if (i == 29) chk("spot_first_frame_blank", bus.seg_out, 7'h7F);
      if (i == 31) chk("spot_d0_shows_40", bus.seg_out, 7'h40);
      if (i == 36) chk("spot_d1_shows_79", bus.seg_out, 7'h79);
      if (i == 61) chk("spot_last_load_wins", bus.seg_out, 7'h24);
      if (i == 91) chk("spot_masked_dig", {1'b0, bus.dig_en}, 7'h00);
    end
    cycle(1'b1, 1'b0, {6{7'h7F}}, 6'h3F);
    chk("spot_reset_pending", {6'b0, bus.pending}, 7'h00);

    // Phase B: restart after reset, then a load coinciding with the swap edge.
    for (int i = 0; i < 95; i++) begin
      ld   = 1'b0;
      segs = {6{7'h7F}};
      case (i)
        20: begin ld = 1'b1; segs[0] = 7'h30; end
        30: begin ld = 1'b1; segs[0] = 7'h06; segs[3] = 7'h5B; end
        default: ;
      endcase
      cycle(1'b0, ld, segs, 6'h3F);
      if (i == 2)  chk("spot_restart_d0_off", bus.seg_out, 7'h7F);
      if (i == 30) chk("spot_swap_edge_pending", {6'b0, bus.pending}, 7'h01);
      if (i == 32) chk("spot_prev_shadow_shown", bus.seg_out, 7'h30);
      if (i == 62) chk("spot_new_shadow_shown", bus.seg_out, 7'h06);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
